tile_store_logic: RTL
=====================

Name: tile_store_logic

Overview:
- Write-side counterpart to the tile fetch path.
- Accepts a stream of data beats over a valid/ready handshake and writes each tile into the shared BRAM. The BRAM holds three logical buffers: Weights, K-Matrix and V-Matrix.
- Keeps an independent next-tile pointer per buffer and generates BRAM write addresses using the same memory map as the fetch path.
- Sits between the compute/projection datapath (producer of K/V and weight tiles) and the BRAM write port.

Parameters:
- NUM_WRITES_PER_TILE, 2, beats (BRAM words) per tile; must be ≥1.
- ADDR_WIDTH, 11, BRAM address width.
- DATA_WIDTH, 256, BRAM word width.
- PTR_WIDTH, 9, width of each per-buffer tile pointer.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start_store  in  1  pulse; begin storing one tile (honoured only in IDLE).
- reset_addr_counters  in  1  pulse; zero all three tile pointers.
- buffer_select  in  2  00 Weights, 01 K-Matrix, 10 V-Matrix, 11 invalid; sampled at start.
- in_data  in  DATA_WIDTH  beat payload.
- in_valid  in  1  beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- bram_addr  out  ADDR_WIDTH  write address.
- bram_wdata  out  DATA_WIDTH  write data.
- bram_en  out  1  BRAM port enable.
- bram_we  out  1  BRAM write enable.
- store_done  out  1  one-cycle pulse after the last beat of a tile is written.
- store_err  out  1  one-cycle pulse when start_store arrives with buffer_select=11.

Behaviour:
- Memory map bases:
  - Weights = 0.
  - K = 4.
  - V = 772.
- Tile base = base[sel] + ptr[sel]*NUM_WRITES_PER_TILE, computed and truncated to ADDR_WIDTH, then latched on IDLE→WRITING.
- States: IDLE, WRITING, DONE (2-bit encoding).
- IDLE:
  - start_store & sel≠11 → WRITING; latch sel and tile base; beat offset = 0.
  - start_store & sel=11 → assert store_err next cycle (registered, 1 cycle); stay IDLE; pointers untouched.
- WRITING:
  - in_ready=1.
  - Handshake (in_valid & in_ready) is combinational in the same cycle: bram_en=bram_we=1, bram_addr=tile_base+offset, bram_wdata=in_data.
  - No handshake (in_valid=0) → bram_en=bram_we=0; offset and address hold.
  - Handshake with offset = NUM_WRITES_PER_TILE-1 → DONE; otherwise offset += 1.
- DONE:
  - store_done=1 for exactly one cycle, in_ready=0.
  - Latched-select pointer += 1 (wraps modulo 2^PTR_WIDTH) → IDLE.
- Outside WRITING: in_ready=0, bram_en=0, bram_we=0. bram_addr and bram_wdata are don't-care but driven stably (tile_base+offset, in_data).
- start_store outside IDLE is ignored. buffer_select changes after the start cycle have no effect on the current tile.
- reset_addr_counters:
  - Zeroes all pointers at the next edge in any state.
  - Takes priority over the DONE increment in the same cycle (result 0).
  - Does not abort a tile in progress; the latched tile base is unaffected.
- Latency:
  - start at cycle t with in_valid held high → writes at t+1 … t+N, store_done at t+N+1, IDLE at t+N+2.
  - Earliest next start_store accepted: cycle t+N+2.
- Reset values:
  - State IDLE; offset, tile_base and all pointers 0.
  - Outputs: in_ready=0, bram_en=0, bram_we=0, store_done=0, store_err=0, bram_addr=0.
  - Reset mid-tile abandons the tile; no store_done; no pointer increment.
- Address overflow beyond 2^ADDR_WIDTH wraps silently (truncation). No range checking against the neighbouring buffer.

Decomposition:
- Shared package (shared with the fetch path):
  - WEIGHT/K/V base address constants.
  - buffer_select encodings (BUF_WEIGHT=2'b00, BUF_K=2'b01, BUF_V=2'b10).
  - Tile FSM state encodings.
- One natural sub-module: tile_ptr_bank.
  - Holds the three pointers.
  - Inputs: clear, incr, sel.
  - Output: base address for a given sel.
  - Reusable by the fetch path.

Test Plan:
- Reset then Weights store with N=2 and in_valid held high: start at t → writes addr 0 at t+1 and addr 1 at t+2; store_done at t+3; second Weights tile writes addr 2, 3.
- K tile0 then V store after two prior V tiles: K writes 4, 5. V writes 776, 777 (772+2·2).
- Backpressure: V tile with in_valid pattern 1,0,0,1 → bram_we high only on the two valid cycles; addresses 772 then 773; in_data captured exactly per beat; store_done one cycle after the second beat.
- reset_addr_counters asserted in the same cycle as DONE of a K tile (ptr was 3) → K pointer reads 0; next K tile writes 4, 5.
- buffer_select=11 with start_store → store_err pulses once, no bram_we, state stays IDLE; start_store pulsed during WRITING is ignored (no extra tile).
- rst asserted after the first beat of a Weights tile (ptr 1) → outputs return to reset values next cycle, no store_done; next Weights tile writes addr 0, 1 (all pointers cleared by rst).

Source files
------------

// File: rtl/tile_store_logic_pkg.sv
// Shared definitions for the tile fetch/store paths: BRAM memory map,
// buffer select encodings and tile FSM state encodings.
package tile_store_logic_pkg;

    localparam int unsigned WEIGHT_BASE = 0;
    localparam int unsigned K_BASE      = 4;
    localparam int unsigned V_BASE      = 772;

    typedef enum logic [1:0] {
        BUF_WEIGHT  = 2'b00,
        BUF_K       = 2'b01,
        BUF_V       = 2'b10,
        BUF_INVALID = 2'b11
    } buf_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_WRITING = 2'b01,
        ST_DONE    = 2'b10
    } tile_state_e;

    // Start address of a logical buffer; the invalid select maps to 0.
    function automatic logic [31:0] buf_base(input logic [1:0] sel);
        case (sel)
            BUF_WEIGHT: buf_base = 32'(WEIGHT_BASE);
            BUF_K:      buf_base = 32'(K_BASE);
            BUF_V:      buf_base = 32'(V_BASE);
            default:    buf_base = 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/tile_ptr_bank.sv
// Per-buffer next-tile pointers plus the tile base address lookup.
// The increment and lookup selects are separate so a caller can bump the
// pointer of the tile just finished while looking up a different buffer.
module tile_ptr_bank
    import tile_store_logic_pkg::*;
#(
    parameter int ADDR_WIDTH          = 11,
    parameter int PTR_WIDTH           = 9,
    parameter int NUM_WRITES_PER_TILE = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  incr,
    input  logic [1:0]            incr_sel,
    input  logic [1:0]            lookup_sel,
    output logic [ADDR_WIDTH-1:0] base_addr
);

    logic [PTR_WIDTH-1:0] w_ptr_q, w_ptr_d;
    logic [PTR_WIDTH-1:0] k_ptr_q, k_ptr_d;
    logic [PTR_WIDTH-1:0] v_ptr_q, v_ptr_d;
    logic [PTR_WIDTH-1:0] lookup_ptr;
    logic [31:0]          full_base;

    // Next pointer values: clear wins over the end-of-tile increment.
    always_comb begin
        w_ptr_d = w_ptr_q;
        k_ptr_d = k_ptr_q;
        v_ptr_d = v_ptr_q;
        if (clear) begin
            w_ptr_d = '0;
            k_ptr_d = '0;
            v_ptr_d = '0;
        end else if (incr) begin
            case (incr_sel)
                BUF_WEIGHT: w_ptr_d = w_ptr_q + 1'b1;
                BUF_K:      k_ptr_d = k_ptr_q + 1'b1;
                BUF_V:      v_ptr_d = v_ptr_q + 1'b1;
                default:    ;
            endcase
        end
    end

    // Pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_ptr_q <= '0;
            k_ptr_q <= '0;
            v_ptr_q <= '0;
        end else begin
            w_ptr_q <= w_ptr_d;
            k_ptr_q <= k_ptr_d;
            v_ptr_q <= v_ptr_d;
        end
    end

    // Tile base = buffer base + pointer * beats per tile, truncated to the port width.
    always_comb begin
        case (lookup_sel)
            BUF_WEIGHT: lookup_ptr = w_ptr_q;
            BUF_K:      lookup_ptr = k_ptr_q;
            BUF_V:      lookup_ptr = v_ptr_q;
            default:    lookup_ptr = '0;
        endcase
        full_base = buf_base(lookup_sel) + 32'(lookup_ptr) * 32'(NUM_WRITES_PER_TILE);
        base_addr = full_base[ADDR_WIDTH-1:0];
    end

endmodule

// File: rtl/tile_store_logic.sv
// Write-side tile engine: accepts NUM_WRITES_PER_TILE beats over valid/ready
// and writes them to consecutive BRAM words starting at the selected
// buffer's next tile, then advances that buffer's pointer.
module tile_store_logic
    import tile_store_logic_pkg::*;
#(
    parameter int NUM_WRITES_PER_TILE = 2,
    parameter int ADDR_WIDTH          = 11,
    parameter int DATA_WIDTH          = 256,
    parameter int PTR_WIDTH           = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_store,
    input  logic                  reset_addr_counters,
    input  logic [1:0]            buffer_select,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_wdata,
    output logic                  bram_en,
    output logic                  bram_we,
    output logic                  store_done,
    output logic                  store_err
);

    localparam int OFF_W = (NUM_WRITES_PER_TILE > 1) ? $clog2(NUM_WRITES_PER_TILE) : 1;
    localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(NUM_WRITES_PER_TILE - 1);

    tile_state_e           state_q, state_d;
    logic [1:0]            sel_q, sel_d;
    logic [ADDR_WIDTH-1:0] tile_base_q, tile_base_d;
    logic [OFF_W-1:0]      offset_q, offset_d;
    logic                  store_err_q, store_err_d;
    logic [ADDR_WIDTH-1:0] lookup_base;

    tile_ptr_bank #(
        .ADDR_WIDTH          (ADDR_WIDTH),
        .PTR_WIDTH           (PTR_WIDTH),
        .NUM_WRITES_PER_TILE (NUM_WRITES_PER_TILE)
    ) u_ptr_bank (
        .clk        (clk),
        .rst        (rst),
        .clear      (reset_addr_counters),
        .incr       (state_q == ST_DONE),
        .incr_sel   (sel_q),
        .lookup_sel (buffer_select),
        .base_addr  (lookup_base)
    );

    // Tile FSM: next state, latched tile context and handshake outputs.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        tile_base_d = tile_base_q;
        offset_d    = offset_q;
        store_err_d = 1'b0;
        in_ready    = 1'b0;
        store_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_store) begin
                    if (buffer_select == BUF_INVALID) begin
                        store_err_d = 1'b1;
                    end else begin
                        state_d     = ST_WRITING;
                        sel_d       = buffer_select;
                        tile_base_d = lookup_base;
                        offset_d    = '0;
                    end
                end
            end
            ST_WRITING: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (offset_q == LAST_OFF) begin
                        state_d  = ST_DONE;
                        offset_d = '0;
                    end else begin
                        offset_d = offset_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                store_done = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and tile context registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= 2'b00;
            tile_base_q <= '0;
            offset_q    <= '0;
            store_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            tile_base_q <= tile_base_d;
            offset_q    <= offset_d;
            store_err_q <= store_err_d;
        end
    end

    // BRAM port: address and data always driven, strobes only on a handshake.
    always_comb begin
        bram_en    = in_ready & in_valid;
        bram_we    = in_ready & in_valid;
        bram_addr  = tile_base_q + ADDR_WIDTH'(offset_q);
        bram_wdata = in_data;
        store_err  = store_err_q;
    end

endmodule
